// File: rtl/alu16_pipe.sv
// Hack-style 16-bit ALU (zx nx zy ny f no) behind a 2-stage valid/ready pipeline.
// Define ALU16_OVF_EN to add the registered signed-overflow output ov.
module alu16_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef ALU16_OVF_EN
  ,
  output logic             ov
`endif
);

  // Stage-1 operand conditioning and function select
  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_xb;
  logic [WIDTH-1:0] w_ya;
  logic [WIDTH-1:0] w_yb;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;

  // Handshake / advance controls
  logic w_s2_free;
  logic w_s1_adv;
  logic w_in_fire;

  // Stage registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_raw;
  logic             r_s1_no;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  always_comb begin
    w_xa  = ctrl[5] ? '0 : x;
    w_xb  = ctrl[4] ? ~w_xa : w_xa;
    w_ya  = ctrl[3] ? '0 : y;
    w_yb  = ctrl[2] ? ~w_ya : w_ya;
    w_and = w_xb & w_yb;
    w_sum = w_xb + w_yb;
    w_raw = ctrl[1] ? w_sum : w_and;
    w_res = r_s1_no ? ~r_s1_raw : r_s1_raw;
  end

  always_comb begin
    w_s2_free = !r_s2_valid || out_ready;
    w_s1_adv  = r_s1_valid && w_s2_free;
    in_ready  = !r_s1_valid || w_s2_free;
    w_in_fire = in_valid && in_ready;
  end

  // S1: loads on accept; empties when its beat moves to S2 with nothing new behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_no    <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_raw   <= w_raw;
        r_s1_no    <= ctrl[0];
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // S2: result registers only change on an advance, so they hold under stall and when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zr       <= 1'b0;
      r_ng       <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_out      <= w_res;
        r_zr       <= (w_res == '0);
        r_ng       <= w_res[WIDTH-1];
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

`ifdef ALU16_OVF_EN
  logic w_ovf;
  logic r_s1_ov;
  logic r_ov;

  // Operands agree in sign but the wrapped sum does not; judged before the no inversion
  always_comb begin
    w_ovf = ctrl[1] && (w_xb[WIDTH-1] == w_yb[WIDTH-1]) &&
            (w_sum[WIDTH-1] != w_xb[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_ov <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_ov <= w_ovf;
      end
      if (w_s1_adv) begin
        r_ov <= r_s1_ov;
      end
    end
  end

  assign ov = r_ov;
`endif

endmodule

// File: tb/tb_alu16_pipe.sv
// Directed bench for alu16_pipe: scoreboard of model results checked at every output transfer.
module tb_alu16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] t_x;
  logic [15:0] t_y;
  logic [5:0]  t_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
`ifdef ALU16_OVF_EN
  logic        ov;
`endif

  alu16_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (t_x),
    .y         (t_y),
    .ctrl      (t_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef ALU16_OVF_EN
    ,
    .ov        (ov)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] res;
    logic        zr;
    logic        ng;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b1;

  bit          hold_v = 1'b0;
  logic [15:0] hold_out;
  logic        hold_zr;
  logic        hold_ng;
  logic        hold_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from the control-bit rules, using integer arithmetic
  function automatic exp_t model(input logic [15:0] a_in, input logic [15:0] b_in,
                                 input logic [5:0] c);
    exp_t        e;
    int unsigned a;
    int unsigned b;
    int unsigned r;
    int          sa;
    int          sb;
    a = c[5] ? 32'd0 : 32'(a_in);
    if (c[4]) a = (~a) & 32'hFFFF;
    b = c[3] ? 32'd0 : 32'(b_in);
    if (c[2]) b = (~b) & 32'hFFFF;
    e.ov = 1'b0;
    if (c[1]) begin
      r  = (a + b) % 65536;
      sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
      sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
      e.ov = ((sa + sb) > 32767) || ((sa + sb) < -32768);
    end else begin
      r = a & b;
    end
    if (c[0]) r = (~r) & 32'hFFFF;
    e.res = 16'(r);
    e.zr  = (r == 0);
    e.ng  = (r >= 32768);
    e.acc = 0;
    return e;
  endfunction

  // Single compare process: transfers are judged at the negedge before the edge that takes them
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (hold_v) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_out", 32'(out), 32'(hold_out));
        chk("stall_zr", 32'(zr), 32'(hold_zr));
        chk("stall_ng", 32'(ng), 32'(hold_ng));
`ifdef ALU16_OVF_EN
        chk("stall_ov", 32'(ov), 32'(hold_ov));
`endif
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out", 32'(out), 32'(e.res));
          chk("zr", 32'(zr), 32'(e.zr));
          chk("ng", 32'(ng), 32'(e.ng));
`ifdef ALU16_OVF_EN
          chk("ov", 32'(ov), 32'(e.ov));
`endif
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_out = out;
      hold_zr  = zr;
      hold_ng  = ng;
`ifdef ALU16_OVF_EN
      hold_ov  = ov;
`else
      hold_ov  = 1'b0;
`endif
      if (in_valid && in_ready) begin
        e     = model(t_x, t_y, t_ctrl);
        e.acc = cyc;
        q.push_back(e);
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Present one beat and return just after the edge that accepted it
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
    int n;
    in_valid = 1'b1;
    t_x      = a;
    t_y      = b;
    t_ctrl   = c;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam int NV = 9;
  logic [15:0] vx   [NV] = '{16'h0011, 16'h0011, 16'h0011, 16'h0011, 16'h0011, 16'h0011,
                             16'hFFFF, 16'h7FFF, 16'h7FFF};
  logic [15:0] vy   [NV] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003,
                             16'h0001, 16'h0001, 16'h0001};
  logic [5:0]  vc   [NV] = '{6'b000000, 6'b000010, 6'b010011, 6'b101010, 6'b111010, 6'b001101,
                             6'b000010, 6'b000010, 6'b000000};
  logic [15:0] vres [NV] = '{16'h0001, 16'h0014, 16'h000E, 16'h0000, 16'hFFFF, 16'hFFEE,
                             16'h0000, 16'h8000, 16'h0001};
  logic        vzr  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        vng  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        vov  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    exp_t m;
    int   n0;
    int   w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t_x       = '0;
    t_y       = '0;
    t_ctrl    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zr", 32'(zr), 32'd0);
    chk("rst_ng", 32'(ng), 32'd0);
`ifdef ALU16_OVF_EN
    chk("rst_ov", 32'(ov), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Literal pins on the model, then the same vectors through the DUT back-to-back
    for (int i = 0; i < NV; i++) begin
      m = model(vx[i], vy[i], vc[i]);
      chk($sformatf("model_res_%0d", i), 32'(m.res), 32'(vres[i]));
      chk($sformatf("model_zr_%0d", i), 32'(m.zr), 32'(vzr[i]));
      chk($sformatf("model_ng_%0d", i), 32'(m.ng), 32'(vng[i]));
`ifdef ALU16_OVF_EN
      chk($sformatf("model_ov_%0d", i), 32'(m.ov), 32'(vov[i]));
`endif
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) push(vx[i], vy[i], vc[i]);
    idle(5);

    // Eight-beat stream, one per cycle
    n0 = n_out;
    for (int i = 0; i < 8; i++) push(16'(i), 16'(5 * i), 6'b000000);
    idle(5);
    chk("stream_count", 32'(n_out - n0), 32'd8);

    // Backpressure: stall the first result for five cycles
    lat_chk = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++) push(16'(16'h00F0 + i), 16'h0F3C, 6'b000010);
        in_valid = 1'b0;
      end
      begin
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!out_valid && w < 50);
        if (!out_valid) chk("bp_wait_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_drain", 32'(n_out - n0), 32'd0);
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_count", 32'(n_out - n0), 32'd4);
    lat_chk = 1'b1;

    // Reset with two beats in flight; nothing may emerge afterwards
    push(16'h1234, 16'h5678, 6'b000010);
    push(16'hAAAA, 16'h5555, 6'b000000);
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_zr", 32'(zr), 32'd0);
    chk("mid_rst_ng", 32'(ng), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    n0 = n_out;
    idle(6);
    chk("mid_rst_silent", 32'(n_out - n0), 32'd0);
    chk("mid_rst_out_valid_late", 32'(out_valid), 32'd0);

    push(16'hFFFF, 16'h0001, 6'b000010);
    idle(5);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
